// File: rtl/avst_gen_pkg.sv
// avst_gen_pkg: shared CSR map, FSM states and empty helper for the packet generator
package avst_gen_pkg;
  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_LEN   = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_SENT  = 2'd3;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  function automatic int unsigned empty_of(input int unsigned rem, input int unsigned db);
    return (rem >= db) ? 0 : db - rem;
  endfunction
endpackage

// File: rtl/avst_pattern_beat.sv
// avst_pattern_beat: incrementing-byte beat data and empty count for one beat
module avst_pattern_beat
  import avst_gen_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int EW         = $clog2(DATA_BYTES)
) (
  input  logic [7:0]              pkt,
  input  logic [LEN_WIDTH-1:0]    off,
  input  logic [LEN_WIDTH-1:0]    rem,
  output logic [DATA_BYTES*8-1:0] data,
  output logic [EW-1:0]           empty
);
  logic [7:0] base;
  assign base = pkt + 8'(off);
  always_comb begin
    data = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      data[(DATA_BYTES-1-i)*8 +: 8] = (32'(i) < 32'(rem)) ? base + 8'(i) : 8'd0;
    empty = EW'(empty_of(32'(rem), DATA_BYTES));
  end
endmodule

// File: rtl/avst_packet_gen.sv
// avst_packet_gen: CSR-controlled Avalon-ST source of incrementing-byte packets
module avst_packet_gen
  import avst_gen_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);
  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_WIDTH-1:0] STEP = LEN_WIDTH'(DATA_BYTES);
  state_t state, state_n;
  logic busy, stop_pend, ld;
  logic [LEN_WIDTH-1:0] len, off, ld_off, rem;
  logic [31:0] count, sent, rd_mux;
  logic [7:0] pkt, ld_pkt;
  logic [GW-1:0] gap_cnt;
  logic [DW-1:0] beat_data;
  logic [EW-1:0] beat_empty;
  logic wr_ok, rd_ok, start, stop_wr, accept, eop_acc, finish, gap_done;
  assign csr_waitrequest = reset | (busy & csr_write & ((csr_address == ADDR_LEN) | (csr_address == ADDR_COUNT)));
  assign wr_ok    = csr_write & ~csr_waitrequest;
  assign rd_ok    = csr_read & ~csr_waitrequest;
  assign start    = wr_ok & (csr_address == ADDR_CTRL) & csr_writedata[0] & (state == IDLE) & (|len) & (|count);
  assign stop_wr  = wr_ok & (csr_address == ADDR_CTRL) & ~csr_writedata[0] & busy;
  assign accept   = stream_out_valid & stream_out_ready;
  assign eop_acc  = accept & stream_out_endofpacket;
  assign finish   = (sent + 32'd1 == count) | stop_pend | stop_wr;
  assign gap_done = gap_cnt == GAP_LAST;
  assign rem      = len - ld_off;
  avst_pattern_beat #(.DATA_BYTES(DATA_BYTES), .LEN_WIDTH(LEN_WIDTH)) u_beat (
    .pkt   (ld_pkt),
    .off   (ld_off),
    .rem   (rem),
    .data  (beat_data),
    .empty (beat_empty)
  );
  always_comb begin
    state_n = state;
    ld      = 1'b0;
    ld_pkt  = pkt;
    ld_off  = '0;
    case (state)
      IDLE: if (start) begin
        state_n = SEND;
        ld      = 1'b1;
        ld_pkt  = '0;
      end
      SEND: if (accept & ~stream_out_endofpacket) begin
        ld     = 1'b1;
        ld_off = off + STEP;
      end else if (eop_acc) begin
        if (finish) state_n = IDLE;
        else if (GAP_CYCLES == 0) begin
          ld     = 1'b1;
          ld_pkt = pkt + 8'd1;
        end else state_n = GAP;
      end
      GAP: if (stop_wr) state_n = IDLE;
        else if (gap_done) begin
          state_n = SEND;
          ld      = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_comb
    rd_mux = (csr_address == ADDR_CTRL) ? {31'd0, busy} :
             (csr_address == ADDR_LEN)  ? 32'(len) :
             (csr_address == ADDR_COUNT) ? count : sent;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      stop_pend <= 1'b0;
      len       <= '0;
      count     <= '0;
      sent      <= '0;
      pkt       <= '0;
      off       <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      busy      <= state_n != IDLE;
      stop_pend <= (state_n != IDLE) & (stop_pend | stop_wr);
      gap_cnt   <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (ld) off <= ld_off;
      if (start) begin
        sent <= '0;
        pkt  <= '0;
      end else if (eop_acc) begin
        sent <= sent + 32'd1;
        pkt  <= pkt + 8'd1;
      end
      if (wr_ok & (csr_address == ADDR_LEN)) len <= csr_writedata[LEN_WIDTH-1:0];
      if (wr_ok & (csr_address == ADDR_COUNT)) count <= csr_writedata;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stream_out_valid         <= 1'b0;
      stream_out_data          <= '0;
      stream_out_empty         <= '0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
    end else if (ld) begin
      stream_out_valid         <= 1'b1;
      stream_out_data          <= beat_data;
      stream_out_empty         <= beat_empty;
      stream_out_startofpacket <= ld_off == '0;
      stream_out_endofpacket   <= rem <= STEP;
    end else if (accept) stream_out_valid <= 1'b0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      csr_readdatavalid <= 1'b0;
      csr_readdata      <= '0;
    end else begin
      csr_readdatavalid <= rd_ok;
      csr_readdata      <= rd_ok ? rd_mux : '0;
    end
endmodule
